// File: rtl/eth_speed_detect.sv
// eth_speed_detect: classifies RX clock rate against the reference clock
// and reports 10/100/1000M link speed with hysteresis and force override.
module eth_speed_detect #(
  parameter int WINDOW_WIDTH = 10,
  parameter int SYNC_STAGES  = 3,
  parameter int THRESH_1000  = 128,
  parameter int THRESH_100   = 24,
  parameter int THRESH_10    = 2,
  parameter int HYST_COUNT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_prescale_toggle,
  input  logic                    cfg_force_en,
  input  logic [1:0]              cfg_force_speed,
  output logic [1:0]              speed,
  output logic                    mii_select,
  output logic                    link_valid,
  output logic                    speed_change,
  output logic [WINDOW_WIDTH-1:0] edge_count
);

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_10   = 2'd1,
    CLS_100  = 2'd2,
    CLS_1000 = 2'd3
  } cls_t;

  localparam logic [WINDOW_WIDTH-1:0] T1000 = WINDOW_WIDTH'(THRESH_1000);
  localparam logic [WINDOW_WIDTH-1:0] T100  = WINDOW_WIDTH'(THRESH_100);
  localparam logic [WINDOW_WIDTH-1:0] T10   = WINDOW_WIDTH'(THRESH_10);
  localparam logic [3:0]              HC    = 4'(HYST_COUNT);
  localparam logic [WINDOW_WIDTH-1:0] ONE   = WINDOW_WIDTH'(1);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_edge;
  logic [WINDOW_WIDTH-1:0] win_cnt;
  logic [WINDOW_WIDTH-1:0] edge_cnt;
  logic [WINDOW_WIDTH-1:0] edge_total;
  logic                    terminal;
  cls_t                    cls;
  cls_t                    cand;
  cls_t                    committed;
  logic [3:0]              stable_cnt;
  logic [3:0]              stable_nxt;
  logic                    commit;
  logic [1:0]              cls_speed;
  logic [1:0]              meas_speed;
  logic                    meas_link;
  logic [1:0]              speed_nxt;

  assign rx_edge  = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];
  assign terminal = &win_cnt;

  // Synchronize the RX-domain toggle into the reference clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_prescale_toggle};
  end

  // Saturating edge total including the current cycle's edge.
  always_comb begin
    edge_total = edge_cnt;
    if (rx_edge && !(&edge_cnt)) edge_total = edge_cnt + ONE;
  end

  // Classify the window total; the highest threshold met wins.
  always_comb begin
    cls       = CLS_NONE;
    cls_speed = 2'b00;
    if (edge_total >= T10) cls = CLS_10;
    if (edge_total >= T100) begin
      cls       = CLS_100;
      cls_speed = 2'b01;
    end
    if (edge_total >= T1000) begin
      cls       = CLS_1000;
      cls_speed = 2'b10;
    end
  end

  // Hysteresis: count consecutive identical classes, commit on a run.
  always_comb begin
    stable_nxt = 4'd1;
    if (cls == cand) begin
      if (stable_cnt >= HC) stable_nxt = HC;
      else                  stable_nxt = stable_cnt + 4'd1;
    end
    commit = terminal && (stable_nxt == HC) && (cls != committed);
  end

  // Window timing, edge counting and candidate tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt    <= '0;
      edge_cnt   <= '0;
      edge_count <= '0;
      cand       <= CLS_NONE;
      stable_cnt <= 4'd0;
    end else begin
      win_cnt <= win_cnt + ONE;
      if (terminal) begin
        edge_cnt   <= '0;
        edge_count <= edge_total;
        cand       <= cls;
        stable_cnt <= stable_nxt;
      end else begin
        edge_cnt <= edge_total;
      end
    end
  end

  // Committed measurement; a lost link keeps the last measured speed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      committed  <= CLS_NONE;
      meas_speed <= 2'b10;
      meas_link  <= 1'b0;
    end else if (commit) begin
      committed <= cls;
      if (cls != CLS_NONE) begin
        meas_speed <= cls_speed;
        meas_link  <= 1'b1;
      end else begin
        meas_link <= 1'b0;
      end
    end
  end

  // Reported speed selects between force value and measurement.
  always_comb begin
    speed_nxt = meas_speed;
    if (cfg_force_en) begin
      if (cfg_force_speed == 2'b11) speed_nxt = 2'b00;
      else                          speed_nxt = cfg_force_speed;
    end
  end

  // Registered outputs with a single change pulse per update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed        <= 2'b10;
      mii_select   <= 1'b0;
      link_valid   <= 1'b0;
      speed_change <= 1'b0;
    end else begin
      speed        <= speed_nxt;
      mii_select   <= ~speed_nxt[1];
      link_valid   <= meas_link;
      speed_change <= (speed_nxt != speed) || (meas_link != link_valid);
    end
  end

endmodule

// File: tb/tb_eth_speed_detect.sv
// tb_eth_speed_detect: randomized RX-rate stimulus with a window-level
// reference model feeding a per-cycle scoreboard.
module tb_eth_speed_detect;

  localparam int W  = 10;
  localparam int S  = 3;
  localparam int WL = 1 << W;
  localparam int HY = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tog = 1'b0;
  logic         force_en = 1'b0;
  logic [1:0]   force_spd = 2'b00;
  logic [1:0]   speed;
  logic         mii_select;
  logic         link_valid;
  logic         speed_change;
  logic [W-1:0] edge_count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  eth_speed_detect dut (
    .clk                (clk),
    .rst                (rst),
    .rx_prescale_toggle (tog),
    .cfg_force_en       (force_en),
    .cfg_force_speed    (force_spd),
    .speed              (speed),
    .mii_select         (mii_select),
    .link_valid         (link_valid),
    .speed_change       (speed_change),
    .edge_count         (edge_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]   spd;
    logic         mii;
    logic         lnk;
    logic         chg;
    logic [W-1:0] ecnt;
  } exp_t;

  exp_t exp_q[$];
  bit   dly[$];
  int   n, tally, run_cls, run_len, com_cls;
  logic [1:0]   m_spd, p_spd;
  logic         m_lnk, p_lnk;
  logic [W-1:0] m_ecnt;

  function automatic int classify(int c);
    if (c >= 128) return 3;
    if (c >= 24)  return 2;
    if (c >= 2)   return 1;
    return 0;
  endfunction

  function automatic logic [1:0] spd_of(int c);
    return (c == 3) ? 2'b10 : (c == 2) ? 2'b01 : 2'b00;
  endfunction

  always @(posedge clk) begin
    exp_t       e;
    bit         ed;
    int         c;
    logic [1:0] o_spd;
    if (rst) begin
      exp_q.delete();
      dly.delete();
      for (int i = 0; i < S; i++) dly.push_back(1'b0);
      n = 0; tally = 0; run_cls = 0; run_len = 0; com_cls = 0;
      m_spd = 2'b10; p_spd = 2'b10; m_lnk = 0; p_lnk = 0; m_ecnt = '0;
    end else begin
      ed = dly[0] ^ dly[1];
      dly.push_back(tog);
      void'(dly.pop_front());
      if (ed && tally < WL - 1) tally++;
      o_spd = force_en ? ((force_spd == 2'b11) ? 2'b00 : force_spd) : m_spd;
      e.spd = o_spd;
      e.mii = ~o_spd[1];
      e.lnk = m_lnk;
      e.chg = (o_spd != p_spd) || (m_lnk != p_lnk);
      p_spd = o_spd;
      p_lnk = m_lnk;
      if (n % WL == WL - 1) begin
        c = classify(tally);
        m_ecnt = W'(tally);
        tally = 0;
        if (c == run_cls) run_len = (run_len < HY) ? run_len + 1 : HY;
        else begin
          run_cls = c;
          run_len = 1;
        end
        if (run_len == HY && run_cls != com_cls) begin
          com_cls = c;
          if (c != 0) begin
            m_spd = spd_of(c);
            m_lnk = 1;
          end else m_lnk = 0;
        end
      end
      e.ecnt = m_ecnt;
      exp_q.push_back(e);
      n++;
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t a, x;
    #1;
    a = {speed, mii_select, link_valid, speed_change, edge_count};
    if (rst) begin
      chk("reset_outputs", 32'(a), 32'({2'b10, 1'b0, 1'b0, 1'b0, W'(0)}));
    end else if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'(0), 32'(1));
    end else begin
      x = exp_q.pop_front();
      chk("cycle_outputs", 32'(a), 32'(x));
      if (speed_change) pulses++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(int per, int ncyc, bit jit);
    int c;
    c = (per > 0) ? int'($urandom_range(1, per)) : 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (per > 0) begin
        c--;
        if (c <= 0) begin
          tog = ~tog;
          c = per + (jit ? int'($urandom_range(0, 2)) - 1 : 0);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_speed", 32'(speed), 32'(2'b10));
    chk("rst_mii", 32'(mii_select), 32'(0));
    chk("rst_link", 32'(link_valid), 32'(0));
    chk("rst_change", 32'(speed_change), 32'(0));
    chk("rst_ecnt", 32'(edge_count), 32'(0));
    repeat (5) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    int per;
    int guard;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // 1000M lock from reset: exact 2 windows + 1 clk
    p0 = pulses;
    drive(4, 2 * WL, 0);
    chk("lock_not_early", 32'(link_valid), 32'(0));
    drive(4, 1, 0);
    chk("lock_link", 32'(link_valid), 32'(1));
    chk("lock_speed", 32'(speed), 32'(2'b10));
    chk("lock_mii", 32'(mii_select), 32'(0));
    drive(4, WL, 0);
    chk("lock_pulses", 32'(pulses - p0), 32'(1));

    // 100M
    p0 = pulses;
    drive(20, 4 * WL, 1);
    chk("m100_speed", 32'(speed), 32'(2'b01));
    chk("m100_mii", 32'(mii_select), 32'(1));
    chk("m100_pulses", 32'(pulses - p0), 32'(1));

    // force 11 during 100M link
    p0 = pulses;
    force_en = 1'b1;
    force_spd = 2'b11;
    drive(20, 1, 1);
    chk("force_speed", 32'(speed), 32'(2'b00));
    chk("force_mii", 32'(mii_select), 32'(1));
    chk("force_link", 32'(link_valid), 32'(1));
    drive(20, 50, 1);
    force_en = 1'b0;
    drive(20, 1, 1);
    chk("unforce_speed", 32'(speed), 32'(2'b01));
    chk("force_pulses", 32'(pulses - p0), 32'(2));

    // link loss keeps speed
    p0 = pulses;
    drive(0, 4 * WL, 0);
    chk("loss_link", 32'(link_valid), 32'(0));
    chk("loss_speed", 32'(speed), 32'(2'b01));
    chk("loss_pulses", 32'(pulses - p0), 32'(1));

    // 10M, then one aligned window of 1000M-rate edges
    p0 = pulses;
    drive(200, 4 * WL, 1);
    chk("m10_speed", 32'(speed), 32'(2'b00));
    chk("m10_link", 32'(link_valid), 32'(1));
    chk("m10_pulses", 32'(pulses - p0), 32'(1));
    guard = 0;
    while (n % WL != 0 && guard < 2 * WL) begin
      drive(200, 1, 0);
      guard++;
    end
    chk("align_guard", 32'(guard < 2 * WL), 32'(1));
    p0 = pulses;
    drive(4, WL, 0);
    drive(200, 3 * WL, 1);
    chk("burst_speed", 32'(speed), 32'(2'b00));
    chk("burst_pulses", 32'(pulses - p0), 32'(0));

    // reset mid-window at 1000M, then relock
    drive(4, 1500, 0);
    do_reset();
    p0 = pulses;
    drive(4, 2 * WL, 0);
    chk("relock_not_early", 32'(link_valid), 32'(0));
    drive(4, 1, 0);
    chk("relock_link", 32'(link_valid), 32'(1));
    chk("relock_speed", 32'(speed), 32'(2'b10));
    chk("relock_pulses", 32'(pulses - p0), 32'(1));

    // randomized rate and force segments
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0:       per = 4;
        1:       per = 20;
        2:       per = 200;
        default: per = 0;
      endcase
      force_en  = ($urandom_range(0, 3) == 0);
      force_spd = 2'($urandom_range(0, 3));
      drive(per, int'($urandom_range(500, 3000)), 1);
    end
    force_en = 1'b0;
    drive(0, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
